diff_buff: RTL

- Backward-difference buffer for the ODE step datapath; the inverse of the accumulating buffer.
- Takes a stream of accumulated 16-bit signed fixed-point values x[n] and emits the increments d[n] = x[n] - x[n-1], with x[-1] = 0.
- A stream produced by the accumulator therefore round-trips back to its original increments.
- Sits between the stored-state buffers and the error/step-control logic, with valid/ready handshakes on both sides.

---
 rtl/diff_pkg.sv | 16 +
 rtl/diff_buff_if.sv | 33 +++
 rtl/diff_buff_addsub.sv | 34 +++
 rtl/diff_buff.sv | 109 ++++++++++
 4 files changed

// File: rtl/diff_pkg.sv
// Shared definitions for the backward-difference buffer: default data
// width, output-register state encoding and saturation limits.
package diff_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Most positive / most negative two's-complement values at DEFAULT_WIDTH.
  localparam logic [DEFAULT_WIDTH-1:0] SAT_MAX = {1'b0, {(DEFAULT_WIDTH-1){1'b1}}};
  localparam logic [DEFAULT_WIDTH-1:0] SAT_MIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/diff_buff_if.sv
// Valid/ready stream bundle for diff_buff: the accumulated-value input side
// and the difference output side. slave is the buffer's view, master is the
// view of whatever drives samples in and consumes differences.
interface diff_buff_if import diff_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inputData;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] outputData;

  modport slave (
    input  in_valid,
    input  inputData,
    output in_ready,
    output out_valid,
    output outputData,
    input  out_ready
  );

  modport master (
    output in_valid,
    output inputData,
    input  in_ready,
    input  out_valid,
    input  outputData,
    output out_ready
  );

endinterface

// File: rtl/diff_buff_addsub.sv
// Fixed-point adder/subtractor in generate/propagate form.
// op=0: sum = a + b ; op=1: sum = a - b (b inverted, carry-in set).
// overflowFlag is the signed overflow of the WIDTH-bit result.
module FixedPoint_AdderSub_CarryLookAhead #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] sum,
  output logic             overflowFlag
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign b_eff = b ^ {WIDTH{op}};
  assign gen   = a & b_eff;
  assign prop  = a ^ b_eff;

  // Carry chain expressed from generate/propagate terms.
  always_comb begin
    carry[0] = op;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign sum          = prop ^ carry[WIDTH-1:0];
  assign overflowFlag = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/diff_buff.sv
// Backward-difference buffer: turns a stream of accumulated values x[n]
// into increments d[n] = x[n] - x[n-1] with x[-1] = 0, one-deep output
// register, full throughput under valid/ready on both sides.
// Optional macro DIFF_SAT_EN: saturate overflowing differences instead of
// emitting the wrapped result.
//
//   state | meaning
//   EMPTY | output register holds no data
//   FULL  | output register holds d[n] awaiting out_ready
module diff_buff import diff_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  diff_buff_if.slave           bus,
  output logic                 overflowFlag,
  output logic [CNT_WIDTH-1:0] sampleCount
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] diff_wrap;
  logic [WIDTH-1:0] diff_out;
  logic             sub_ovf;
  logic             accept;
  logic             retire;

  FixedPoint_AdderSub_CarryLookAhead #(
    .WIDTH(WIDTH)
  ) u_sub (
    .a           (bus.inputData),
    .b           (prev),
    .op          (1'b1),
    .sum         (diff_wrap),
    .overflowFlag(sub_ovf)
  );

`ifdef DIFF_SAT_EN
  // Clamp to the rail matching the sign of the incoming value on overflow.
  always_comb begin
    diff_out = diff_wrap;
    if (sub_ovf) begin
      diff_out = bus.inputData[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign diff_out = diff_wrap;
`endif

  // clear blocks intake so a sample arriving with it is not half-absorbed.
  assign bus.in_ready   = enable & ~clear & ((state == EMPTY) | bus.out_ready);
  assign bus.out_valid  = (state == FULL);
  assign bus.outputData = dout;

  assign accept = bus.in_valid & bus.in_ready;
  assign retire = bus.out_valid & bus.out_ready & enable & ~clear;

  // State register.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state: accept refills (even while retiring), lone retire empties.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = EMPTY;
    end else if (accept) begin
      state_next = FULL;
    end else if (retire) begin
      state_next = EMPTY;
    end
  end

  // Datapath: previous value, output register, sticky overflow, counter.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      prev         <= '0;
      dout         <= '0;
      overflowFlag <= 1'b0;
      sampleCount  <= '0;
    end else if (clear) begin
      prev         <= '0;
      overflowFlag <= 1'b0;
      sampleCount  <= '0;
    end else begin
      if (accept) begin
        dout <= diff_out;
        prev <= bus.inputData;
        if (sub_ovf) begin
          overflowFlag <= 1'b1;
        end
      end
      if (retire) begin
        sampleCount <= sampleCount + 1'b1;
      end
    end
  end

endmodule
